// File: rtl/tmr_pkg.sv
// Shared constants for the IOBUS timer/interrupt block.
//   Register offsets are word indices (ADDR[3:2]) within the 16-byte window.
//   CTRL bit indices select EN, RELOAD and IE within the CTRL register.
package tmr_pkg;

  localparam logic [1:0] TMR_OFF_CTRL   = 2'd0;
  localparam logic [1:0] TMR_OFF_LOAD   = 2'd1;
  localparam logic [1:0] TMR_OFF_COUNT  = 2'd2;
  localparam logic [1:0] TMR_OFF_STATUS = 2'd3;

  localparam int unsigned TMR_CTRL_EN     = 0;
  localparam int unsigned TMR_CTRL_RELOAD = 1;
  localparam int unsigned TMR_CTRL_IE     = 2;

endpackage

// File: rtl/iobus_timer_intc_if.sv
// MCU IOBUS as seen by a peripheral.
//   TMR_IOBUS_ADDR : byte address from the MCU
//   TMR_IOBUS_OUT  : write data
//   TMR_IOBUS_WR   : one-cycle write strobe
//   TMR_IOBUS_IN   : read data returned by the peripheral
// master: the MCU side; slave: the peripheral side.
interface iobus_timer_intc_if;

  logic [31:0] TMR_IOBUS_ADDR;
  logic [31:0] TMR_IOBUS_OUT;
  logic        TMR_IOBUS_WR;
  logic [31:0] TMR_IOBUS_IN;

  modport master (
    output TMR_IOBUS_ADDR,
    output TMR_IOBUS_OUT,
    output TMR_IOBUS_WR,
    input  TMR_IOBUS_IN
  );

  modport slave (
    input  TMR_IOBUS_ADDR,
    input  TMR_IOBUS_OUT,
    input  TMR_IOBUS_WR,
    output TMR_IOBUS_IN
  );

endinterface

// File: rtl/iobus_tmr_prescaler.sv
// Clock prescaler for the timer: counts 0..PRESCALE_DIV-1 while enabled and
// emits a one-cycle tick on the last count.
//   clk, rst_n : clock and asynchronous active-low reset
//   en         : count enable; counter holds 0 while low
//   restart    : force the counter back to 0
//   tick       : high in the cycle where the counter equals PRESCALE_DIV-1
module iobus_tmr_prescaler #(
  parameter int unsigned PRESCALE_DIV = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CntW = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
  localparam logic [CntW-1:0] MaxCnt = CntW'(PRESCALE_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == MaxCnt);

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (!en || restart || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/iobus_timer_intc.sv
// Memory-mapped countdown timer with level interrupt on the MCU IOBUS.
//   TMR_clk, TMR_RST_n : clock and asynchronous active-low reset
//   bus                : IOBUS slave (address, write data, write strobe, read data)
//   TMR_INTR           : PEND & IE, level interrupt to the MCU
// Registers: 0x0 CTRL {IE,RELOAD,EN}, 0x4 LOAD, 0x8 COUNT (ro), 0xC STATUS {PEND} (w1c).
module iobus_timer_intc
  import tmr_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h1100_0300,
  parameter int unsigned PRESCALE_DIV = 16,
  parameter int unsigned CNT_W        = 32
) (
  input  logic                 TMR_clk,
  input  logic                 TMR_RST_n,
  iobus_timer_intc_if.slave    bus,
  output logic                 TMR_INTR
);

  logic             en_q, en_d, reload_q, reload_d, ie_q, ie_d, pend_q, pend_d;
  logic [CNT_W-1:0] load_q, load_d, count_q, count_d;
  logic             hit, wr_ctrl, wr_load, wr_status;
  logic [1:0]       off;
  logic             restart, tick, tick_eff;
  logic [31:0]      wdata;
  logic             unused_bits;

  assign wdata       = bus.TMR_IOBUS_OUT;
  assign hit         = (bus.TMR_IOBUS_ADDR[31:4] == BASE_ADDR[31:4]);
  assign off         = bus.TMR_IOBUS_ADDR[3:2];
  assign wr_ctrl     = bus.TMR_IOBUS_WR && hit && (off == TMR_OFF_CTRL);
  assign wr_load     = bus.TMR_IOBUS_WR && hit && (off == TMR_OFF_LOAD);
  assign wr_status   = bus.TMR_IOBUS_WR && hit && (off == TMR_OFF_STATUS);
  assign unused_bits = ^{bus.TMR_IOBUS_ADDR[1:0], wdata};

  // Prescaler restarts only on an EN 0->1 transition written by software.
  assign restart = wr_ctrl && wdata[TMR_CTRL_EN] && !en_q;

  // A CTRL write that clears EN swallows a coincident tick.
  assign tick_eff = tick && !(wr_ctrl && !wdata[TMR_CTRL_EN]);

  iobus_tmr_prescaler #(
    .PRESCALE_DIV (PRESCALE_DIV)
  ) u_prescaler (
    .clk     (TMR_clk),
    .rst_n   (TMR_RST_n),
    .en      (en_q),
    .restart (restart),
    .tick    (tick)
  );

  always_comb begin
    en_d     = en_q;
    reload_d = reload_q;
    ie_d     = ie_q;
    pend_d   = pend_q;
    load_d   = load_q;
    count_d  = count_q;

    // Clear first so a coincident expiry below wins.
    if (wr_status && wdata[0]) begin
      pend_d = 1'b0;
    end

    if (tick_eff) begin
      if (count_q != '0) begin
        count_d = count_q - CNT_W'(1);
      end else begin
        pend_d = 1'b1;
        if (reload_q) begin
          count_d = load_q;
        end else begin
          en_d = 1'b0;
        end
      end
    end

    if (wr_ctrl) begin
      en_d     = wdata[TMR_CTRL_EN];
      reload_d = wdata[TMR_CTRL_RELOAD];
      ie_d     = wdata[TMR_CTRL_IE];
    end

    // LOAD write overrides any decrement or reload in the same edge.
    if (wr_load) begin
      load_d  = wdata[CNT_W-1:0];
      count_d = wdata[CNT_W-1:0];
    end
  end

  always_ff @(posedge TMR_clk or negedge TMR_RST_n) begin
    if (!TMR_RST_n) begin
      en_q     <= 1'b0;
      reload_q <= 1'b0;
      ie_q     <= 1'b0;
      pend_q   <= 1'b0;
      load_q   <= '0;
      count_q  <= '0;
    end else begin
      en_q     <= en_d;
      reload_q <= reload_d;
      ie_q     <= ie_d;
      pend_q   <= pend_d;
      load_q   <= load_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    bus.TMR_IOBUS_IN = '0;
    if (hit) begin
      case (off)
        TMR_OFF_CTRL:   bus.TMR_IOBUS_IN = {29'd0, ie_q, reload_q, en_q};
        TMR_OFF_LOAD:   bus.TMR_IOBUS_IN = 32'(load_q);
        TMR_OFF_COUNT:  bus.TMR_IOBUS_IN = 32'(count_q);
        default:        bus.TMR_IOBUS_IN = {31'd0, pend_q};
      endcase
    end
  end

  assign TMR_INTR = pend_q && ie_q;

endmodule

// File: tb/tb_iobus_timer_intc.sv
// Directed bench for iobus_timer_intc with PRESCALE_DIV=4.
module tb_iobus_timer_intc;

  localparam logic [31:0] ACtrl   = 32'h1100_0300;
  localparam logic [31:0] ALoad   = 32'h1100_0304;
  localparam logic [31:0] ACount  = 32'h1100_0308;
  localparam logic [31:0] AStatus = 32'h1100_030C;

  logic clk;
  logic rst_n;
  logic intr;
  int   checks;
  int   failures;

  iobus_timer_intc_if bus ();

  iobus_timer_intc #(
    .BASE_ADDR    (32'h1100_0300),
    .PRESCALE_DIV (4),
    .CNT_W        (32)
  ) dut (
    .TMR_clk   (clk),
    .TMR_RST_n (rst_n),
    .bus       (bus),
    .TMR_INTR  (intr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [31:0] a, input string tag, input logic [31:0] exp);
    bus.TMR_IOBUS_ADDR = a;
    #1;
    chk(tag, bus.TMR_IOBUS_IN, exp);
  endtask

  task automatic chk_intr(input string tag, input logic exp);
    chk(tag, {31'd0, intr}, {31'd0, exp});
  endtask

  // Write lands on the next rising edge; returns 1 time unit after it.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.TMR_IOBUS_ADDR = a;
    bus.TMR_IOBUS_OUT  = d;
    bus.TMR_IOBUS_WR   = 1'b1;
    @(posedge clk);
    #1;
    bus.TMR_IOBUS_WR   = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    checks               = 0;
    failures             = 0;
    rst_n                = 1'b0;
    bus.TMR_IOBUS_ADDR   = '0;
    bus.TMR_IOBUS_OUT    = '0;
    bus.TMR_IOBUS_WR     = 1'b0;

    // Reset values
    #2;
    chk_intr("rst_intr", 1'b0);
    rd(ACtrl,   "rst_ctrl",   32'h0);
    rd(ALoad,   "rst_load",   32'h0);
    rd(ACount,  "rst_count",  32'h0);
    rd(AStatus, "rst_status", 32'h0);
    cyc(2);
    rst_n = 1'b1;
    cyc(1);

    // One-shot: LOAD=3, CTRL=EN|IE -> expiry at E16 after CTRL write
    wr(ALoad, 32'd3);
    rd(ALoad,  "os_load",  32'd3);
    rd(ACount, "os_count0", 32'd3);
    wr(ACtrl, 32'h5);
    rd(ACtrl, "os_ctrl_run", 32'h5);
    cyc(4);
    rd(ACount, "os_count_e4", 32'd2);
    cyc(11);
    chk_intr("os_intr_e15", 1'b0);
    rd(ACount, "os_count_e15", 32'd0);
    cyc(1);
    chk_intr("os_intr_e16", 1'b1);
    rd(ACtrl,   "os_ctrl_done", 32'h4);
    rd(ACount,  "os_count_done", 32'd0);
    rd(AStatus, "os_pend", 32'd1);
    wr(AStatus, 32'd1);
    chk_intr("os_intr_clr", 1'b0);
    rd(AStatus, "os_pend_clr", 32'd0);

    // Decode: out-of-window write and COUNT write are ignored
    wr(32'h1100_0404, 32'hDEAD_BEEF);
    rd(32'h1100_0404, "dec_outside", 32'h0);
    rd(ALoad, "dec_load", 32'd3);
    rd(ACtrl, "dec_ctrl", 32'h4);
    wr(ACount, 32'h55);
    rd(ACount, "dec_count_ro", 32'd0);

    // Auto-reload: LOAD=1, CTRL=7 -> expiry every 8 cycles
    wr(ALoad, 32'd1);
    wr(ACtrl, 32'h7);
    cyc(7);
    chk_intr("ar_intr_e7", 1'b0);
    rd(ACount, "ar_count_e7", 32'd0);
    cyc(1);
    chk_intr("ar_intr_e8", 1'b1);
    rd(ACount, "ar_count_e8", 32'd1);
    cyc(1);
    wr(AStatus, 32'd1);
    chk_intr("ar_intr_clr", 1'b0);
    cyc(5);
    chk_intr("ar_intr_e15", 1'b0);
    cyc(1);
    chk_intr("ar_intr_e16", 1'b1);

    // Collision: STATUS clear on the expiry edge E24
    cyc(7);
    wr(AStatus, 32'd1);
    chk_intr("col_intr", 1'b1);
    rd(AStatus, "col_pend", 32'd1);
    rd(ACount,  "col_count", 32'd1);

    // Asynchronous reset mid-count with COUNT=5
    wr(ALoad, 32'd5);
    cyc(1);
    rd(ACount, "mid_count", 32'd5);
    chk_intr("mid_intr_pre", 1'b1);
    rst_n = 1'b0;
    #1;
    chk_intr("arst_intr", 1'b0);
    rd(ACount,  "arst_count",  32'h0);
    rd(ACtrl,   "arst_ctrl",   32'h0);
    rd(ALoad,   "arst_load",   32'h0);
    rd(AStatus, "arst_status", 32'h0);
    cyc(1);
    rst_n = 1'b1;
    cyc(1);

    // IE masking: one-shot LOAD=0 expires on first tick with IE=0
    wr(ALoad, 32'd0);
    wr(ACtrl, 32'h1);
    cyc(3);
    rd(AStatus, "ie_pend_e3", 32'd0);
    cyc(1);
    rd(AStatus, "ie_pend_e4", 32'd1);
    chk_intr("ie_masked", 1'b0);
    rd(ACtrl, "ie_ctrl_done", 32'h0);
    wr(ACtrl, 32'h4);
    chk_intr("ie_unmasked", 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
